rtc_init_sequencer: RTL

//  Parametrised RTC power-up/init sequencer. On start it walks a table of N_ENTRIES
//  (address, data) pairs and presents each pair to the RTC bus controller for

---
 rtl/rtc_pkg.sv | 21 ++
 rtl/rtc_init_rom.sv | 40 ++++
 rtl/rtc_init_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rtc_pkg.sv
// Shared RTC definitions: register addresses, init data bytes and the
// sequencer state encoding.
package rtc_pkg;

  // RTC register map
  localparam logic [7:0] ST_CTRL   = 8'h02;  // status / control register
  localparam logic [7:0] SEC_FIRST = 8'h21;  // first seconds/date register (8'h21 .. 8'h28)
  localparam logic [7:0] TMR_FIRST = 8'h41;  // first timer register (8'h41 .. 8'h43)

  // Init data bytes
  localparam logic [7:0] INIT_CTRL_DATA  = 8'h08;  // first ST_CTRL write
  localparam logic [7:0] INIT_CLEAR_DATA = 8'h00;  // every other register is cleared

  // Sequencer FSM states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } seq_state_e;

endpackage

// File: rtl/rtc_init_rom.sv
// Init table: maps an entry index to its (address, data) pair.
// Purely combinational; the sequencer registers the result.
module rtc_init_rom
  import rtc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 5
) (
  input  logic [IDX_W-1:0]  idx_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o
);

  int          entry_k;
  logic [7:0]  addr8;
  logic [7:0]  data8;

  assign entry_k = int'(idx_i);

  // Table lookup: ctrl set, ctrl clear, 8 seconds/date regs, 3 timer regs
  always_comb begin
    addr8 = 8'h00;
    data8 = INIT_CLEAR_DATA;
    case (entry_k)
      0: begin
        addr8 = ST_CTRL;
        data8 = INIT_CTRL_DATA;
      end
      1: addr8 = ST_CTRL;
      2, 3, 4, 5, 6, 7, 8, 9: addr8 = SEC_FIRST + 8'(entry_k - 2);
      10, 11, 12: addr8 = TMR_FIRST + 8'(entry_k - 10);
      default: addr8 = 8'h00;
    endcase
  end

  assign addr_o = ADDR_W'(addr8);
  assign data_o = DATA_W'(data8);

endmodule

// File: rtl/rtc_init_sequencer.sv
// RTC power-up sequencer: walks the init table, presenting each pair for
// HOLD_CYCLES clocks with a one-cycle write strobe at the start of each entry.
// Supports abort, loop mode and a level-held done flag.
module rtc_init_sequencer
  import rtc_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int N_ENTRIES   = 13,
  parameter int HOLD_CYCLES = 74,
  parameter int IDX_W       = 5,
  parameter int CNT_W       = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_en,
  output logic              busy,
  output logic              done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_CYCLES);

  seq_state_e        state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] address_q, address_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              wr_en_q, wr_en_d;
  logic              load;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  // The ROM is addressed with the next index so the pair is registered on
  // the same edge that enters the entry.
  rtc_init_rom #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_rom (
    .idx_i  (idx_d),
    .addr_o (rom_addr),
    .data_o (rom_data)
  );

  // Next-state logic: start handshake, per-entry hold count, loop/finish, abort
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start && !abort) begin
          state_d = S_RUN;
          idx_d   = '0;
          cnt_d   = CNT_W'(1);
          load    = 1'b1;
        end
      end
      S_RUN: begin
        // Abort takes priority over the end-of-entry transition.
        if (abort) begin
          state_d = S_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (cnt_q == HOLD_MAX) begin
          if (idx_q < LAST_IDX) begin
            idx_d = idx_q + IDX_W'(1);
            cnt_d = CNT_W'(1);
            load  = 1'b1;
          end else if (loop_en) begin
            idx_d = '0;
            cnt_d = CNT_W'(1);
            load  = 1'b1;
          end else begin
            state_d = S_DONE;
            idx_d   = '0;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // Outputs hold their last pair except when a new entry is loaded.
    wr_en_d   = load;
    address_d = load ? rom_addr : address_q;
    data_d    = load ? rom_data : data_q;
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      address_q <= '0;
      data_q    <= '0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      address_q <= address_d;
      data_q    <= data_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign address  = address_q;
  assign data_out = data_q;
  assign wr_en    = wr_en_q;
  assign busy     = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);

endmodule
